bram_tree: RTL and testbench
============================

BRAM_TREE -- requirements
Module: bram_tree

Interface
REQ-001 SHALL have parameter QUEUE_SIZE, default 7, the maximum number of stored entries (any value >= 1).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, the entry width in bits (unsigned keys).
REQ-003 SHALL have port CLK, input, 1 bit, the single clock; all logic on its rising edge.
REQ-004 SHALL have port RSTn, input, 1 bit, an asynchronous, active-high reset (1 = reset), despite the port name.
REQ-005 SHALL have port i_wrt, input, 1 bit, the write/insert request, sampled at a rising edge.
REQ-006 SHALL have port i_read, input, 1 bit, the read/remove-root request, sampled at a rising edge.
REQ-007 SHALL have port i_data, input, DATA_WIDTH bits, the key to insert or replace with.
REQ-008 SHALL have port o_full, output, 1 bit, high when count == QUEUE_SIZE.
REQ-009 SHALL have port o_empty, output, 1 bit, high when count == 0.
REQ-010 SHALL have port o_data, output, DATA_WIDTH bits, the current maximum key, or 0 when empty.

Function
REQ-011 SHALL implement a binary max-heap of up to QUEUE_SIZE keys in one RAM: array index 0 is the root, and the children of i are 2i+1 and 2i+2. Duplicates are allowed.
REQ-012 SHALL keep a count register of width clog2(QUEUE_SIZE+1); o_full and o_empty SHALL be decoded combinationally from count.
REQ-013 SHALL implement the states IDLE, UP_RD, UP_CMP, DN_RD, DN_CMP, and DONE; requests are accepted only in IDLE.
REQ-014 i_wrt=1, i_read=0 (enqueue): if not full, write i_data at index count, count+1, then sift-up (UP_RD/UP_CMP: read the parent, swap if the child > the parent, stop at the root or when no swap occurs). If full, ignore it and stay IDLE.
REQ-015 i_wrt=0, i_read=1 (dequeue): if not empty, move entry count-1 to index 0, count-1, then sift-down (DN_RD reads both children, DN_CMP swaps with the larger child if it is > the node; stop at a leaf or when no swap occurs). If empty, ignore it.
REQ-016 i_wrt=1, i_read=1 (replace): if not empty, write i_data to index 0 with count unchanged, then sift-down. If empty, behave as enqueue.
REQ-017 Requests arriving while not in IDLE SHALL be ignored; there is no ready output, and the user waits for the latency bound.
REQ-018 count, o_full, and o_empty SHALL reflect the new value from the cycle after the accepting edge.
REQ-019 DONE SHALL load o_data from RAM index 0, or load 0 if count == 0, and then return to IDLE.
REQ-020 o_data SHALL be stable (old value) during an operation and final no later than 20 cycles after the accepting edge, for QUEUE_SIZE = 7.
REQ-021 Sift-down SHALL treat a child index >= count as absent. Sift-up SHALL terminate at index 0.
REQ-022 Comparisons SHALL be unsigned over the full DATA_WIDTH; there is no arithmetic beyond index math.

Reset
REQ-023 While RSTn=1, the design SHALL asynchronously set: state=IDLE, count=0, o_data=0, o_empty=1, o_full=0.
REQ-024 RAM contents need not be reset; count=0 makes them don't-care.
REQ-025 Reset asserted mid-operation SHALL abort it immediately; the queue is empty afterwards.

Structure
REQ-026 Package bram_tree_pkg SHALL hold the state enum typedef and the ADDR_WIDTH = clog2(QUEUE_SIZE) helper.
REQ-027 Sub-module bram_tree_ram SHALL have QUEUE_SIZE x DATA_WIDTH depth, with one write port and two synchronous read ports (1-cycle read latency), and no reset.
REQ-028 The top-level SHALL contain only the FSM, the count, the index registers, and the o_data register.

Verification (wait 25 cycles after each request before checking)
REQ-029 Reset, then idle -> o_empty=1, o_full=0, o_data=0.
REQ-030 Enqueue 5, 900, 12, 900, 300, 7, 44 -> o_data=900 after the 2nd insert, o_full=1 after the 7th; an 8th enqueue of 1000 is ignored (o_data stays 900).
REQ-031 Dequeue 7 times from that state -> o_data sequence 900, 300, 44, 12, 7, 5, 0, with o_empty=1 at the end; an extra dequeue leaves o_data=0.
REQ-032 With keys {10, 20, 30} stored, replace with 25 -> o_data=25, and count stays 3. Replace with 1 -> o_data=20. Replace on an empty queue with 9 -> o_data=9, count=1.
REQ-033 Run 100 random operations (keys 0..1024) against a sorted reference model -> o_data equals the reference maximum (0 if empty) after each one, and the flags always match.
REQ-034 Assert reset mid-sift after an enqueue -> the outputs return to their reset values within the same cycle, and a subsequent enqueue of 3 gives o_data=3.

Source files
------------

// File: rtl/bram_tree_pkg.sv
// Shared types and sizing helpers for the block-RAM backed max-heap priority queue.
package bram_tree_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UP_RD,
        UP_CMP,
        DN_RD,
        DN_CMP,
        DONE
    } state_t;

    // Address width for a RAM of the given depth; never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bram_tree_ram.sv
// Heap storage: one write port, two registered read ports, write-first on address collision.
module bram_tree_ram
    import bram_tree_pkg::*;
#(
    parameter int DEPTH = 7,
    parameter int WIDTH = 16,
    parameter int AW    = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    raddr [2];
    logic [WIDTH-1:0] rdata [2];

    assign raddr[0] = raddr_a;
    assign raddr[1] = raddr_b;
    assign rdata_a  = rdata[0];
    assign rdata_b  = rdata[1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Bypass lets the FSM read the root in the same cycle it writes the final key there.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        always_ff @(posedge clk) begin
            rdata[gi] <= (we && (waddr == raddr[gi])) ? wdata : mem[raddr[gi]];
        end
    end

endmodule

// File: rtl/bram_tree.sv
// Max-heap priority queue: the moving key is held in a register and written once at its final slot.
module bram_tree
    import bram_tree_pkg::*;
#(
    parameter int QUEUE_SIZE = 7,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  i_wrt,
    input  logic                  i_read,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DATA_WIDTH-1:0] o_data
);

    localparam int AW = addr_width(QUEUE_SIZE);
    localparam int CW = $clog2(QUEUE_SIZE + 1);
    localparam int IW = CW + 1;

    state_t                state_reg, state_next;
    logic [CW-1:0]         count_reg, count_next;
    logic [AW-1:0]         idx_reg, idx_next;
    logic [DATA_WIDTH-1:0] key_reg, key_next;
    logic                  load_reg, load_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;

    logic                  we;
    logic [AW-1:0]         waddr, raddr_a, raddr_b;
    logic [DATA_WIDTH-1:0] wdata, rdata_a, rdata_b;

    logic [IW-1:0]         child_l, child_r;
    logic [AW-1:0]         parent, big_idx;
    logic                  left_ok, right_ok, big_right;
    logic [DATA_WIDTH-1:0] key_cur, big_val;

    bram_tree_ram #(
        .DEPTH(QUEUE_SIZE),
        .WIDTH(DATA_WIDTH),
        .AW   (AW)
    ) u_ram (
        .clk    (CLK),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr_a(raddr_a),
        .raddr_b(raddr_b),
        .rdata_a(rdata_a),
        .rdata_b(rdata_b)
    );

    assign o_full  = (count_reg == CW'(QUEUE_SIZE));
    assign o_empty = (count_reg == '0);
    assign o_data  = data_reg;

    assign child_l   = (IW'(idx_reg) << 1) + IW'(1);
    assign child_r   = (IW'(idx_reg) << 1) + IW'(2);
    assign parent    = (idx_reg - AW'(1)) >> 1;
    assign left_ok   = (child_l < IW'(count_reg));
    assign right_ok  = (child_r < IW'(count_reg));
    // On dequeue the last entry arrives from RAM in DN_RD instead of from the key register.
    assign key_cur   = load_reg ? rdata_a : key_reg;
    assign big_right = right_ok && (rdata_b > rdata_a);
    assign big_val   = big_right ? rdata_b : rdata_a;
    assign big_idx   = big_right ? child_r[AW-1:0] : child_l[AW-1:0];

    always_ff @(posedge CLK or posedge RSTn) begin
        if (RSTn) begin
            state_reg <= IDLE;
            count_reg <= '0;
            idx_reg   <= '0;
            key_reg   <= '0;
            load_reg  <= 1'b0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            idx_reg   <= idx_next;
            key_reg   <= key_next;
            load_reg  <= load_next;
            data_reg  <= data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        idx_next   = idx_reg;
        key_next   = key_reg;
        load_next  = load_reg;
        data_next  = data_reg;
        we         = 1'b0;
        waddr      = idx_reg;
        wdata      = key_reg;
        raddr_a    = '0;
        raddr_b    = '0;
        case (state_reg)
            IDLE: begin
                if (i_wrt && (!i_read || count_reg == '0)) begin
                    if (count_reg != CW'(QUEUE_SIZE)) begin
                        count_next = count_reg + CW'(1);
                        idx_next   = count_reg[AW-1:0];
                        key_next   = i_data;
                        state_next = UP_RD;
                    end
                end else if (i_wrt && i_read) begin
                    idx_next   = '0;
                    key_next   = i_data;
                    load_next  = 1'b0;
                    state_next = DN_RD;
                end else if (i_read && count_reg != '0) begin
                    count_next = count_reg - CW'(1);
                    idx_next   = '0;
                    raddr_a    = AW'(count_reg - CW'(1));
                    load_next  = 1'b1;
                    state_next = DN_RD;
                end
            end
            UP_RD: begin
                if (idx_reg == '0) begin
                    we         = 1'b1;
                    state_next = DONE;
                end else begin
                    raddr_a    = parent;
                    state_next = UP_CMP;
                end
            end
            UP_CMP: begin
                we = 1'b1;
                if (key_reg > rdata_a) begin
                    wdata      = rdata_a;
                    idx_next   = parent;
                    state_next = UP_RD;
                end else begin
                    state_next = DONE;
                end
            end
            DN_RD: begin
                load_next = 1'b0;
                key_next  = key_cur;
                if (!left_ok) begin
                    we         = 1'b1;
                    wdata      = key_cur;
                    state_next = DONE;
                end else begin
                    raddr_a    = child_l[AW-1:0];
                    raddr_b    = right_ok ? child_r[AW-1:0] : '0;
                    state_next = DN_CMP;
                end
            end
            DN_CMP: begin
                we = 1'b1;
                if (big_val > key_reg) begin
                    wdata      = big_val;
                    idx_next   = big_idx;
                    state_next = DN_RD;
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                data_next  = (count_reg == '0) ? '0 : rdata_a;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bram_tree.sv
// Directed and model-checked stimulus for the bram_tree max-heap priority queue.
module tb_bram_tree;

    localparam int QS = 7;
    localparam int DW = 16;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b1;
    logic          i_wrt = 1'b0;
    logic          i_read = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          o_full, o_empty;
    logic [DW-1:0] o_data;

    int tests = 0;
    int fails = 0;
    int unsigned model[$];

    bram_tree #(.QUEUE_SIZE(QS), .DATA_WIDTH(DW)) dut (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .i_wrt  (i_wrt),
        .i_read (i_read),
        .i_data (i_data),
        .o_full (o_full),
        .o_empty(o_empty),
        .o_data (o_data)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RSTn = 1'b1;
        repeat (3) @(negedge CLK);
        RSTn = 1'b0;
        @(negedge CLK);
    endtask

    task automatic do_op(input logic w, input logic r, input logic [DW-1:0] d);
        @(negedge CLK);
        i_wrt  = w;
        i_read = r;
        i_data = d;
        @(negedge CLK);
        i_wrt  = 1'b0;
        i_read = 1'b0;
        repeat (25) @(negedge CLK);
        $display("[TB] op wrt=%0b read=%0b data=%0d -> o_data=%0d full=%0b empty=%0b",
                 w, r, d, o_data, o_full, o_empty);
    endtask

    task automatic op_exp(input string tag, input logic w, input logic r, input logic [DW-1:0] d,
                          input int exp_data, input logic exp_full, input logic exp_empty);
        do_op(w, r, d);
        check_eq({tag, ".data"}, 32'(o_data), 32'(exp_data));
        check_eq({tag, ".full"}, 32'(o_full), 32'(exp_full));
        check_eq({tag, ".empty"}, 32'(o_empty), 32'(exp_empty));
    endtask

    function automatic int unsigned model_max();
        int unsigned m = 0;
        foreach (model[i]) if (model[i] > m) m = model[i];
        return m;
    endfunction

    task automatic model_op(input logic w, input logic r, input int unsigned d);
        if (w && (!r || model.size() == 0)) begin
            if (model.size() < QS) model.push_back(d);
        end else if (r && model.size() > 0) begin
            int unsigned m = model_max();
            int k = 0;
            for (int i = 0; i < model.size(); i++) if (model[i] == m) k = i;
            model.delete(k);
            if (w) model.push_back(d);
        end
    endtask

    int unsigned ins_keys [7] = '{5, 900, 12, 900, 300, 7, 44};
    int unsigned ins_exp  [7] = '{5, 900, 900, 900, 900, 900, 900};
    int unsigned deq_exp  [7] = '{900, 300, 44, 12, 7, 5, 0};

    initial begin
        do_reset();
        check_eq("reset.empty", 32'(o_empty), 32'd1);
        check_eq("reset.full", 32'(o_full), 32'd0);
        check_eq("reset.data", 32'(o_data), 32'd0);

        for (int i = 0; i < 7; i++)
            op_exp($sformatf("enq%0d", i), 1'b1, 1'b0, DW'(ins_keys[i]), int'(ins_exp[i]), (i == 6), 1'b0);
        op_exp("enq_full", 1'b1, 1'b0, 16'd1000, 900, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++)
            op_exp($sformatf("deq%0d", i), 1'b0, 1'b1, '0, int'(deq_exp[i]), 1'b0, (i == 6));
        op_exp("deq_empty", 1'b0, 1'b1, '0, 0, 1'b0, 1'b1);

        op_exp("r_enq10", 1'b1, 1'b0, 16'd10, 10, 1'b0, 1'b0);
        op_exp("r_enq20", 1'b1, 1'b0, 16'd20, 20, 1'b0, 1'b0);
        op_exp("r_enq30", 1'b1, 1'b0, 16'd30, 30, 1'b0, 1'b0);
        op_exp("rep25", 1'b1, 1'b1, 16'd25, 25, 1'b0, 1'b0);
        check_eq("rep25.count", 32'(dut.count_reg), 32'd3);
        op_exp("rep1", 1'b1, 1'b1, 16'd1, 20, 1'b0, 1'b0);
        check_eq("rep1.count", 32'(dut.count_reg), 32'd3);
        op_exp("r_deq0", 1'b0, 1'b1, '0, 10, 1'b0, 1'b0);
        op_exp("r_deq1", 1'b0, 1'b1, '0, 1, 1'b0, 1'b0);
        op_exp("r_deq2", 1'b0, 1'b1, '0, 0, 1'b0, 1'b1);
        op_exp("rep_empty", 1'b1, 1'b1, 16'd9, 9, 1'b0, 1'b0);
        check_eq("rep_empty.count", 32'(dut.count_reg), 32'd1);

        do_reset();
        model.delete();
        for (int n = 0; n < 100; n++) begin
            logic w, r;
            logic [DW-1:0] d;
            int sel = int'($urandom_range(0, 3));
            w = (sel == 0 || sel == 1 || sel == 3);
            r = (sel == 2 || sel == 3);
            d = DW'($urandom_range(0, 1024));
            do_op(w, r, d);
            model_op(w, r, int'(d));
            check_eq($sformatf("rnd%0d.data", n), 32'(o_data), model_max());
            check_eq($sformatf("rnd%0d.full", n), 32'(o_full), 32'(model.size() == QS));
            check_eq($sformatf("rnd%0d.empty", n), 32'(o_empty), 32'(model.size() == 0));
        end

        do_reset();
        op_exp("a_enq50", 1'b1, 1'b0, 16'd50, 50, 1'b0, 1'b0);
        op_exp("a_enq60", 1'b1, 1'b0, 16'd60, 60, 1'b0, 1'b0);
        @(negedge CLK);
        i_wrt  = 1'b1;
        i_data = 16'd70;
        @(negedge CLK);
        i_wrt  = 1'b0;
        @(posedge CLK);
        #1;
        check_eq("a_stable.data", 32'(o_data), 32'd60);
        #1 RSTn = 1'b1;
        #1;
        check_eq("a_rst.data", 32'(o_data), 32'd0);
        check_eq("a_rst.empty", 32'(o_empty), 32'd1);
        check_eq("a_rst.full", 32'(o_full), 32'd0);
        @(negedge CLK);
        RSTn = 1'b0;
        op_exp("a_enq3", 1'b1, 1'b0, 16'd3, 3, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
